pipelined_addsub: RTL

Parametrised, multi-cycle add/subtract unit. Splits a WIDTH-bit operation into STAGES equal chunks, adds one chunk per pipeline stage and registers the chunk carry between stages. This keeps the carry chain per cycle to WIDTH/STAGES bits. It sits between the operand-issue logic and the writeback path, uses a valid/ready handshake on both sides, and reports carry-out, signed overflow and a zero flag with each result.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result channels of the pipelined add/subtract unit.
// master drives operands and out_ready; slave is the arithmetic unit.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Chunked add/subtract pipeline: one WIDTH/STAGES-bit chunk per stage, carry registered between.
// Optional output saturation on signed overflow when ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] sa_q;
  logic [STAGES-1:0] sb_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];

  logic [STAGES-1:0] stage_ready;
  logic [STAGES-1:0] prev_valid;
  logic [STAGES-1:0] prev_carry;
  logic [STAGES-1:0] prev_sa;
  logic [STAGES-1:0] prev_sb;
  logic [WIDTH-1:0]  prev_sum [STAGES];
  logic [WIDTH-1:0]  prev_a   [STAGES];
  logic [WIDTH-1:0]  prev_b   [STAGES];
  logic [WIDTH-1:0]  sum_d    [STAGES];
  logic [STAGES-1:0] carry_d;
  logic [CW:0]       chunk    [STAGES];

  logic [WIDTH-1:0]  raw_sum;
  logic [WIDTH-1:0]  res_sum;
  logic              ovf;

  // A stage can load if it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_ready[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) stage_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    prev_valid[0] = bus.in_valid;
    prev_a[0]     = bus.in_a;
    prev_b[0]     = bus.in_sub ? ~bus.in_b : bus.in_b;
    prev_carry[0] = bus.in_sub | bus.in_cin;
    prev_sum[0]   = '0;
    prev_sa[0]    = bus.in_a[WIDTH-1];
    prev_sb[0]    = prev_b[0][WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_a[k]     = a_q[k-1];
      prev_b[k]     = b_q[k-1];
      prev_carry[k] = carry_q[k-1];
      prev_sum[k]   = sum_q[k-1];
      prev_sa[k]    = sa_q[k-1];
      prev_sb[k]    = sb_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, prev_a[k][k*CW +: CW]} + {1'b0, prev_b[k][k*CW +: CW]}
               + {{CW{1'b0}}, prev_carry[k]};
      sum_d[k] = prev_sum[k];
      sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
      carry_d[k] = chunk[k][CW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= prev_valid[k];
          if (prev_valid[k]) begin
            sum_q[k]   <= sum_d[k];
            a_q[k]     <= prev_a[k];
            b_q[k]     <= prev_b[k];
            carry_q[k] <= carry_d[k];
            sa_q[k]    <= prev_sa[k];
            sb_q[k]    <= prev_sb[k];
          end
        end
      end
    end
  end

  always_comb begin
    raw_sum = sum_q[LAST];
    ovf     = valid_q[LAST] && (sa_q[LAST] == sb_q[LAST]) && (raw_sum[WIDTH-1] != sa_q[LAST]);
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      res_sum = sa_q[LAST] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_sum = raw_sum;
    end
`else
    res_sum = raw_sum;
`endif
  end

  assign bus.in_ready  = stage_ready[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_sum   = res_sum;
  assign bus.out_cout  = carry_q[LAST];
  assign bus.out_ovf   = ovf;
  // Gated by valid so an idle or freshly reset output never claims a zero result.
  assign bus.out_zero  = valid_q[LAST] && (res_sum == '0);

endmodule
